sal_axi_a_arbiter: RTL and testbench
====================================

// Module: sal_axi_a_arbiter
// PURPOSE
//  Arbitrates the AXI read-address (AR) and write-address (AW) channels into one registered request stream.
//  That stream feeds the DRAM address decoder. Replaces fixed AW-over-AR precedence with a streak-limited policy.
//  The policy keeps the current direction (minimises rd/wr turnaround) but bounds starvation of the other one.
//  Owns the rd/wr sequence-number counters; each granted request carries its per-direction seq_num.
// PARAMETERS
//  MAX_STREAK   4   max consecutive grants to one direction while the other is pending; legal 1..255
//  STREAK_W     $clog2(MAX_STREAK+1)   derived; width of streak counter; not overridden
// PORTS
//  clk          in   1               clock; single clock domain
//  rst_n        in   1               reset, asynchronous, active-low
//  ar_valid     in   1               AR request valid
//  ar_ready     out  1               AR accepted this cycle
//  ar_id        in   axi_id_t        AR transaction id
//  ar_addr      in   axi_addr_t      AR byte address
//  ar_len       in   axi_len_t       AR burst length
//  aw_valid/aw_ready/aw_id/aw_addr/aw_len   same as AR, for write-address channel
//  req_valid    out  1               registered request valid toward decoder
//  req_ready    in   1               decoder accepts request
//  req_wr       out  1               1 = write, 0 = read
//  req_id       out  axi_id_t        granted id
//  req_addr     out  axi_addr_t      granted address (decoder splits ba/ra/ca)
//  req_len      out  axi_len_t       granted length
//  req_seq_num  out  seq_num_t       per-direction sequence number of this request
// BEHAVIOUR
//  - Reset (async assert, sync deassert at rst_n rise): req_valid=0, all req_* payload=0.
//    rd_seq=wr_seq=0; last_dir=WR; streak=0. ar_ready/aw_ready are combinational and therefore 0 while req slot is blocked.
//  - Output slot: one entry. load_en = !req_valid | req_ready. Full throughput: drain and load in the same cycle allowed.
//  - Latency: AR/AW handshake in cycle N -> req_valid with that payload in N+1.
//  - Stability: while req_valid & !req_ready, all req_* hold unchanged; no handshake on AR/AW.
//  - Grant (combinational, only when load_en):
//      only one channel valid -> grant it.
//      both valid -> grant last_dir if streak<MAX_STREAK, else grant the other direction.
//  - ar_ready = load_en & grant_rd; aw_ready = load_en & grant_wr. Never both 1 in a cycle.
//    Ready may depend on valid; valid never depends on ready.
//  - On grant: capture id/addr/len; req_wr = grant_wr; req_seq_num = wr_seq (write) or rd_seq (read).
//    Increment that counter by 1, mod 2^SEQ_NUM_WIDTH; wraps silently (max -> 0).
//  - Streak: grant in same direction as last_dir -> streak+1, saturating at MAX_STREAK.
//    Grant in other direction -> streak=1 and last_dir flips. No grant -> streak and last_dir hold.
//    A lone-valid grant counts toward streak like any other grant.
//  - MAX_STREAK=1 gives strict alternation when both are continuously valid.
//  - Reset mid-operation: pending req slot discarded (not replayed); counters restart at 0. Upstream shares rst_n.
// STRUCTURE
//  - Package (SAL_DDR_PARAMS): axi_id_t, axi_addr_t, axi_len_t, seq_num_t, SEQ_NUM_WIDTH.
//    Add enum dir_t {DIR_RD=1'b0, DIR_WR=1'b1}.
//  - Sub-module sal_req_slice: one-entry valid/ready register slice (load_en, payload hold, async reset).
//    The arbiter keeps grant logic, streak FSM and seq counters.
//  - Assertions: onehot0({ar_ready,aw_ready}); req_* stable while req_valid & !req_ready; streak<=MAX_STREAK.
// TESTING
//  1 Reset: rst_n=0 mid-burst with req_valid=1 -> req_valid=0 same cycle; after release, first AW grant carries seq 0.
//  2 AR only, req_ready=1, 5 back-to-back reads -> 5 consecutive ar_ready.
//    req_valid one cycle later, seq 0..4, req_wr=0, no bubbles.
//  3 AR and AW both valid continuously, MAX_STREAK=4, req_ready=1 -> grants WWWW RRRR WWWW...
//    Each direction's seq_num increments by 1 per grant.
//  4 Backpressure: req_ready=0 for 3 cycles with req_valid=1 -> req_* constant, ar_ready=aw_ready=0.
//    req_ready=1 -> next grant loads same cycle.
//  5 Wrap: drive 2^SEQ_NUM_WIDTH+1 writes -> req_seq_num goes max then 0 then 1; rd_seq unchanged.
//  6 MAX_STREAK=1, both valid -> strict W,R,W,R alternation. AR drops -> consecutive W grants continue.

Source files
------------

// File: rtl/sal_axi_a_arbiter_pkg.sv
// sal_axi_a_arbiter_pkg: shared AXI address/request types for the AR/AW arbiter
package sal_axi_a_arbiter_pkg;
  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_LEN_WIDTH  = 8;
  localparam int SEQ_NUM_WIDTH  = 4;
  typedef logic [AXI_ID_WIDTH-1:0]   axi_id_t;
  typedef logic [AXI_ADDR_WIDTH-1:0] axi_addr_t;
  typedef logic [AXI_LEN_WIDTH-1:0]  axi_len_t;
  typedef logic [SEQ_NUM_WIDTH-1:0]  seq_num_t;
  typedef enum logic {DIR_RD = 1'b0, DIR_WR = 1'b1} dir_t;
  typedef struct packed {
    logic      wr;
    axi_id_t   id;
    axi_addr_t addr;
    axi_len_t  len;
    seq_num_t  seq;
  } req_t;
endpackage

// File: rtl/sal_req_slice.sv
// sal_req_slice: one-entry valid/ready register slice with async active-low reset
module sal_req_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_out_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_load_en
);
  logic         r_valid;
  logic [W-1:0] r_data;
  assign o_load_en = !r_valid | i_out_ready;
  assign o_valid   = r_valid;
  assign o_data    = r_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_load_en) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end
endmodule

// File: rtl/sal_axi_a_arbiter.sv
// sal_axi_a_arbiter: streak-limited AR/AW arbiter feeding a registered request slot with per-direction seq numbers
module sal_axi_a_arbiter
  import sal_axi_a_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      ar_valid,
  output logic      ar_ready,
  input  axi_id_t   ar_id,
  input  axi_addr_t ar_addr,
  input  axi_len_t  ar_len,
  input  logic      aw_valid,
  output logic      aw_ready,
  input  axi_id_t   aw_id,
  input  axi_addr_t aw_addr,
  input  axi_len_t  aw_len,
  output logic      req_valid,
  input  logic      req_ready,
  output logic      req_wr,
  output axi_id_t   req_id,
  output axi_addr_t req_addr,
  output axi_len_t  req_len,
  output seq_num_t  req_seq_num
);
  localparam int STREAK_W = $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
  logic                w_load_en, w_keep, w_grant_wr, w_grant_rd, w_take;
  dir_t                r_last_dir, w_dir;
  logic [STREAK_W-1:0] r_streak;
  seq_num_t            r_rd_seq, r_wr_seq;
  req_t                w_req_in, w_req_out;
  // With both pending, stay on last_dir until the streak limit, then yield
  assign w_keep     = r_streak < STREAK_MAX;
  assign w_grant_wr = aw_valid & (!ar_valid | ((r_last_dir == DIR_WR) == w_keep));
  assign w_grant_rd = ar_valid & !w_grant_wr;
  assign ar_ready   = w_load_en & w_grant_rd;
  assign aw_ready   = w_load_en & w_grant_wr;
  assign w_take     = ar_ready | aw_ready;
  assign w_dir      = dir_t'(w_grant_wr);
  assign w_req_in   = '{wr:   w_grant_wr,
                        id:   w_grant_wr ? aw_id   : ar_id,
                        addr: w_grant_wr ? aw_addr : ar_addr,
                        len:  w_grant_wr ? aw_len  : ar_len,
                        seq:  w_grant_wr ? r_wr_seq : r_rd_seq};
  sal_req_slice #(.W($bits(req_t))) u_slice (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (w_take),
    .i_data      (w_req_in),
    .i_out_ready (req_ready),
    .o_valid     (req_valid),
    .o_data      (w_req_out),
    .o_load_en   (w_load_en)
  );
  assign req_wr      = w_req_out.wr;
  assign req_id      = w_req_out.id;
  assign req_addr    = w_req_out.addr;
  assign req_len     = w_req_out.len;
  assign req_seq_num = w_req_out.seq;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_dir <= DIR_WR;
      r_streak   <= '0;
      r_rd_seq   <= '0;
      r_wr_seq   <= '0;
    end else if (w_take) begin
      r_last_dir <= w_dir;
      r_streak   <= (w_dir != r_last_dir) ? STREAK_W'(1) :
                    (r_streak == STREAK_MAX) ? r_streak : r_streak + 1'b1;
      if (w_grant_wr) r_wr_seq <= r_wr_seq + 1'b1;
      else            r_rd_seq <= r_rd_seq + 1'b1;
    end
  end
  a_onehot_ready: assert property (@(posedge clk) disable iff (!rst_n) $onehot0({ar_ready, aw_ready}));
  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    req_valid && !req_ready |=> req_valid && $stable(w_req_out));
  a_streak_max: assert property (@(posedge clk) disable iff (!rst_n) r_streak <= STREAK_MAX);
endmodule

// File: tb/tb_sal_axi_a_arbiter.sv
// tb_sal_axi_a_arbiter: table-driven directed bench for the streak-limited AR/AW arbiter
module tb_sal_axi_a_arbiter;
  import sal_axi_a_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ar_valid = 1'b0, aw_valid = 1'b0, req_ready = 1'b0;
  axi_id_t   ar_id = 4'd3, aw_id = 4'd5;
  axi_addr_t ar_addr = '0, aw_addr = '0;
  axi_len_t  ar_len = '0, aw_len = '0;
  logic      ar_ready, aw_ready, req_valid, req_wr;
  axi_id_t   req_id;
  axi_addr_t req_addr;
  axi_len_t  req_len;
  seq_num_t  req_seq_num;
  logic      ar_ready1, aw_ready1, req_valid1, req_wr1;
  axi_id_t   req_id1;
  axi_addr_t req_addr1;
  axi_len_t  req_len1;
  seq_num_t  req_seq_num1;
  always #5 clk = ~clk;
  sal_axi_a_arbiter #(.MAX_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_id(req_id),
    .req_addr(req_addr), .req_len(req_len), .req_seq_num(req_seq_num)
  );
  sal_axi_a_arbiter #(.MAX_STREAK(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .ar_valid(ar_valid), .ar_ready(ar_ready1), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
    .aw_valid(aw_valid), .aw_ready(aw_ready1), .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len),
    .req_valid(req_valid1), .req_ready(req_ready), .req_wr(req_wr1), .req_id(req_id1),
    .req_addr(req_addr1), .req_len(req_len1), .req_seq_num(req_seq_num1)
  );
  typedef struct {
    logic arv, awv, rdy, ear, eaw, erv, ewr;
    logic [3:0] eseq;
  } vec_t;
  vec_t      tbl[$];
  int        n_vec = 0, n_bad = 0, stp = 0;
  axi_addr_t exp_addr = '0;
  axi_id_t   exp_id = '0;
  axi_len_t  exp_len = '0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", nm, act, exp, stp);
    end
  endtask
  task automatic add(input logic arv, awv, rdy, ear, eaw, erv, ewr, input int eseq);
    tbl.push_back('{arv, awv, rdy, ear, eaw, erv, ewr, 4'(eseq)});
  endtask
  task automatic apply(input vec_t v);
    @(negedge clk);
    ar_valid = v.arv; aw_valid = v.awv; req_ready = v.rdy;
    ar_addr = 32'h1000_0000 | stp; aw_addr = 32'h2000_0000 | stp;
    ar_len = stp[7:0]; aw_len = ~stp[7:0];
    #1;
    chk("ar_ready", ar_ready, v.ear);
    chk("aw_ready", aw_ready, v.eaw);
    chk("req_valid", req_valid, v.erv);
    if (v.erv) begin
      chk("req_wr", req_wr, v.ewr);
      chk("req_seq_num", req_seq_num, v.eseq);
      chk("req_addr", req_addr, exp_addr);
      chk("req_id", req_id, exp_id);
      chk("req_len", req_len, exp_len);
    end
    if (v.ear) begin exp_addr = ar_addr; exp_id = ar_id; exp_len = ar_len; end
    else if (v.eaw) begin exp_addr = aw_addr; exp_id = aw_id; exp_len = aw_len; end
    stp++;
  endtask
  initial begin
    add(1,0,1, 1,0, 0,0,0); add(1,0,1, 1,0, 1,0,0); add(1,0,1, 1,0, 1,0,1);
    add(1,0,1, 1,0, 1,0,2); add(1,0,1, 1,0, 1,0,3); add(0,0,1, 0,0, 1,0,4);
    add(0,0,1, 0,0, 0,0,0);
    add(1,1,1, 0,1, 0,0,0); add(1,1,1, 0,1, 1,1,0); add(1,1,1, 0,1, 1,1,1);
    add(1,1,1, 0,1, 1,1,2); add(1,1,1, 1,0, 1,1,3); add(1,1,1, 1,0, 1,0,5);
    add(1,1,1, 1,0, 1,0,6); add(1,1,1, 1,0, 1,0,7); add(1,1,1, 0,1, 1,0,8);
    add(1,1,1, 0,1, 1,1,4);
    add(1,1,0, 0,0, 1,1,5); add(1,1,0, 0,0, 1,1,5); add(1,1,0, 0,0, 1,1,5);
    add(1,1,1, 0,1, 1,1,5); add(0,0,1, 0,0, 1,1,6); add(0,0,1, 0,0, 0,0,0);
    add(1,0,0, 1,0, 0,0,0); add(0,1,0, 0,0, 1,0,9); add(0,1,1, 0,1, 1,0,9);
    add(0,0,1, 0,0, 1,1,7); add(0,0,0, 0,0, 0,0,0);
    for (int k = 0; k < 17; k++) add(0,1,1, 0,1, k > 0, 1, (8 + k - 1) % 16);
    add(1,0,1, 1,0, 1,1,8);
    add(0,0,1, 0,0, 1,0,10);
    repeat (2) @(negedge clk);
    chk("rst req_valid", req_valid, 0);
    chk("rst req_addr", req_addr, 0);
    chk("rst req_seq_num", req_seq_num, 0);
    chk("rst req_wr", req_wr, 0);
    rst_n = 1'b1;
    foreach (tbl[i]) apply(tbl[i]);
    @(negedge clk);
    ar_valid = 1'b0; aw_valid = 1'b1; req_ready = 1'b0;
    @(negedge clk);
    #1 chk("pre-reset req_valid", req_valid, 1);
    #2 rst_n = 1'b0; aw_valid = 1'b0;
    #1 chk("mid-reset req_valid", req_valid, 0);
    chk("mid-reset req_valid1", req_valid1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int wc = 0, rc = 0;
      logic ew, pw = 1'b0;
      logic [3:0] ps = '0;
      for (int k = 0; k < 9; k++) begin
        @(negedge clk);
        ar_valid = k < 6; aw_valid = 1'b1; req_ready = 1'b1;
        #1;
        ew = (k >= 6) || (k % 2 == 0);
        chk("alt aw_ready", aw_ready1, ew);
        chk("alt ar_ready", ar_ready1, !ew);
        if (k == 0) chk("post-reset aw_ready", aw_ready, 1);
        if (k == 1) begin
          chk("post-reset req_wr", req_wr, 1);
          chk("post-reset req_seq_num", req_seq_num, 0);
        end
        if (k > 0) begin
          chk("alt req_wr", req_wr1, pw);
          chk("alt req_seq_num", req_seq_num1, ps);
        end
        pw = ew;
        ps = 4'(ew ? wc : rc);
        if (ew) wc++; else rc++;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
